// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, default
// parameter values and the 2-of-3 majority vote used for every bit sample.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_CLK_DIV    = 651;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
  localparam int DEF_STOP_BITS  = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side stream between the UART receiver and its consumer.
// Handshake: a word transfers on every rising clk edge where rx_valid and
// rx_ready are both high; rx_valid never depends on rx_ready, and rx_data
// holds its value while rx_valid is high and rx_ready is low.
interface uart_rx_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO. A push while full is accepted only when a pop frees
// the head slot in the same cycle; a pop on an empty FIFO is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_ok    = pop & not_empty;
  assign push_ok   = push & (~full | pop_ok);
  assign head      = mem[rd_ptr];

  // Storage, power-of-two pointer wrap and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchronizer, majority-of-3 mid-bit
// voting, optional parity, 1 or 2 stop bits, and a receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_in,
  uart_rx_param_if.master rx_bus,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy,
  output rx_state_t       dbg_state
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;
  localparam logic                 ODD_BIT   = (PARITY_ODD != 0);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]      OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      SAMP_LO   = OS_W'(MID - 1);
  localparam logic [OS_W-1:0]      SAMP_MID  = OS_W'(MID);
  localparam logic [OS_W-1:0]      SAMP_HI   = OS_W'(MID + 1);
  localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);

  logic                 sync1, sync2, rx;
  rx_state_t            state_q, state_d;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [3:0]           bit_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frm_err_q;
  logic                 tick, at_vote, at_end, vote, decide, final_frm, good;
  logic                 fifo_full, fifo_ne, pop;
  logic [DATA_BITS-1:0] fifo_head;

  assign rx        = sync2;
  assign tick      = (state_q != ST_IDLE) && (div_cnt == DIV_LAST);
  assign at_vote   = tick && (os_cnt == SAMP_HI);
  assign at_end    = tick && (os_cnt == OS_LAST);
  assign vote      = vote3(samp[0], samp[1], rx);
  assign final_frm = frm_err_q | ~vote;
  assign good      = decide & ~final_frm & ~par_err_q;
  assign pop       = fifo_ne & rx_bus.rx_ready;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  assign rx_bus.rx_data  = fifo_head;
  assign rx_bus.rx_valid = fifo_ne;

  // Bring the asynchronous line into the clk domain; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; decide marks the mid-sample of the last stop bit.
  always_comb begin
    state_d = state_q;
    decide  = 1'b0;
    case (state_q)
      ST_IDLE:   if (!rx) state_d = ST_START;
      ST_START: begin
        if (at_vote && vote) state_d = ST_IDLE;
        else if (at_end)     state_d = ST_DATA;
      end
      ST_DATA:   if (at_end && bit_cnt == LAST_DATA)
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_end) state_d = ST_STOP;
      ST_STOP: begin
        if (at_vote && bit_cnt == LAST_STOP) begin
          state_d = ST_IDLE;
          decide  = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Tick divider, bit-tick counter, vote samples, payload and error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      samp      <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        os_cnt <= at_end ? '0 : os_cnt + OS_W'(1);
        if (os_cnt == SAMP_LO)  samp[0] <= rx;
        if (os_cnt == SAMP_MID) samp[1] <= rx;
        if (at_vote) begin
          case (state_q)
            ST_DATA:   shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            ST_PARITY: if (vote != ((^shift_q) ^ ODD_BIT)) par_err_q <= 1'b1;
            ST_STOP:   if (!vote) frm_err_q <= 1'b1;
            default:   ;
          endcase
        end
        if (at_end) bit_cnt <= (state_d != state_q) ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

  // Outcome pulses, registered from the decision cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= decide & final_frm;
      parity_err <= decide & par_err_q;
      overrun    <= good & fifo_full & ~pop;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (good),
    .push_data (shift_q),
    .pop       (pop),
    .head      (fifo_head),
    .not_empty (fifo_ne),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance, both with
// 64 clocks per bit. Frames are described at the bit level; a queue model
// holds the bytes that must come out and the flag pulses that must occur.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;
  localparam int DEPTH    = 4;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      rx0 = 1'b1;
  logic      rx1 = 1'b1;
  logic      fe0, pe0, ov0, busy0, fe1, pe1, ov1, busy1;
  rx_state_t st0, st1;

  uart_rx_param_if #(.WIDTH(8)) bus0 ();
  uart_rx_param_if #(.WIDTH(8)) bus1 ();

  uart_rx_param #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .clk(clk), .reset(rst), .rx_in(rx0), .rx_bus(bus0), .frame_err(fe0),
    .parity_err(pe0), .overrun(ov0), .busy(busy0), .dbg_state(st0)
  );

  uart_rx_param #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .reset(rst), .rx_in(rx1), .rx_bus(bus1), .frame_err(fe1),
    .parity_err(pe1), .overrun(ov1), .busy(busy1), .dbg_state(st1)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] pop_log0[$];
  int         n_fe[2], n_pe[2], n_ov[2], e_fe[2], e_pe[2], e_ov[2], n_valid[2];
  logic [7:0] last_data[2];
  int         ready_mode = 1;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  // consumer: ready low, high or random for dut0; always high for dut1
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus0.rx_ready = 1'b0;
      1:       bus0.rx_ready = 1'b1;
      default: bus0.rx_ready = 1'($urandom_range(0, 1));
    endcase
    bus1.rx_ready = 1'b1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // scoreboard: every cycle a DUT offers data it must match the model head
  always @(negedge clk) begin
    if (fe0) n_fe[0]++;
    if (pe0) n_pe[0]++;
    if (ov0) n_ov[0]++;
    if (fe1) n_fe[1]++;
    if (pe1) n_pe[1]++;
    if (ov1) n_ov[1]++;
    if (!rst) begin
      if (bus0.rx_valid) begin
        n_valid[0]++;
        last_data[0] = bus0.rx_data;
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid0: got data 0x%0h, required no data", bus0.rx_data);
        end else begin
          cmp("data0", bus0.rx_data, exp_q0[0]);
          if (bus0.rx_ready) begin
            pop_log0.push_back(bus0.rx_data);
            void'(exp_q0.pop_front());
          end
        end
      end
      if (bus1.rx_valid) begin
        n_valid[1]++;
        last_data[1] = bus1.rx_data;
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid1: got data 0x%0h, required no data", bus1.rx_data);
        end else begin
          cmp("data1", bus1.rx_data, exp_q1[0]);
          void'(exp_q1.pop_front());
        end
      end
    end
  end

  // model: parity bit that makes the frame satisfy the selected parity
  function automatic logic model_parity(input logic [7:0] d, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return logic'(ones % 2 == 1) ^ odd;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  // driver: par_mode 0 = no parity bit, 1 = correct, 2 = wrong
  task automatic send_frame(input int sel, input logic [7:0] data, input int par_mode,
                            input logic stop_val);
    logic bad_par, bad_stop;
    int   occ;
    bad_par  = (par_mode == 2);
    bad_stop = !stop_val;
    if (bad_stop) e_fe[sel]++;
    if (bad_par)  e_pe[sel]++;
    if (!bad_par && !bad_stop) begin
      occ = (sel == 0) ? exp_q0.size() : exp_q1.size();
      if (sel == 0 && ready_mode == 0 && occ >= DEPTH) e_ov[0]++;
      else if (sel == 0) exp_q0.push_back(data);
      else               exp_q1.push_back(data);
    end
    drive_line(sel, 1'b0);
    cycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, data[i]);
      cycles(BIT_CLKS);
    end
    if (par_mode != 0) begin
      drive_line(sel, model_parity(data, 1'b0) ^ bad_par);
      cycles(BIT_CLKS);
    end
    drive_line(sel, stop_val);
    cycles(BIT_CLKS);
    drive_line(sel, 1'b1);
    cycles(bad_stop ? 2 * BIT_CLKS : 8);
  endtask

  task automatic check_flags(input string tag);
    for (int s = 0; s < 2; s++) begin
      cmp($sformatf("%s_frame_err%0d", tag, s), n_fe[s], e_fe[s]);
      cmp($sformatf("%s_parity_err%0d", tag, s), n_pe[s], e_pe[s]);
      cmp($sformatf("%s_overrun%0d", tag, s), n_ov[s], e_ov[s]);
    end
  endtask

  task automatic drain(input string tag);
    ready_mode = 1;
    for (int i = 0; i < 300 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) cycles(1);
    cmp({tag, "_pending0"}, exp_q0.size(), 0);
    cmp({tag, "_pending1"}, exp_q1.size(), 0);
  endtask

  initial begin
    int         v0, v1;
    logic [7:0] d;
    logic       err;
    int         pm;

    rst = 1'b1;
    cycles(5);
    @(negedge clk);
    cmp("reset_valid0", bus0.rx_valid, 0);
    cmp("reset_data0", bus0.rx_data, 0);
    cmp("reset_busy0", busy0, 0);
    cmp("reset_flags0", {fe0, pe0, ov0}, 0);
    cmp("reset_state0", st0, ST_IDLE);
    cmp("reset_valid1", bus1.rx_valid, 0);
    cmp("model_par_3c_even", model_parity(8'h3C, 1'b0), 0);
    cmp("model_par_07_even", model_parity(8'h07, 1'b0), 1);
    cmp("model_par_07_odd", model_parity(8'h07, 1'b1), 0);
    rst = 1'b0;
    cycles(10);

    // 8N1 frame 0xA5
    v0 = n_valid[0];
    send_frame(0, 8'hA5, 0, 1'b1);
    cmp("a5_valid_cycles", n_valid[0] - v0, 1);
    cmp("a5_data", last_data[0], 8'hA5);
    check_flags("a5");

    // half-bit glitch
    v0 = n_valid[0];
    rx0 = 1'b0;
    cycles(32);
    rx0 = 1'b1;
    cycles(4);
    @(negedge clk);
    cmp("glitch_busy_mid", busy0, 1);
    cycles(100);
    @(negedge clk);
    cmp("glitch_busy_after", busy0, 0);
    cmp("glitch_state_after", st0, ST_IDLE);
    cmp("glitch_no_write", n_valid[0] - v0, 0);
    check_flags("glitch");

    // parity error on 0x3C, then a correct parity frame
    v1 = n_valid[1];
    send_frame(1, 8'h3C, 2, 1'b1);
    cmp("par_err_pulses", n_pe[1], 1);
    cmp("par_no_write", n_valid[1] - v1, 0);
    check_flags("par");
    d = 8'($urandom);
    send_frame(1, d, 1, 1'b1);
    cmp("par_good_data", last_data[1], d);
    cmp("par_good_write", n_valid[1] - v1, 1);

    // bad stop on 0x55, then good 0x12
    v0 = n_valid[0];
    send_frame(0, 8'h55, 0, 1'b0);
    cmp("stop_frame_err_pulses", n_fe[0], 1);
    cmp("stop_no_write", n_valid[0] - v0, 0);
    send_frame(0, 8'h12, 0, 1'b1);
    cmp("after_stop_data", last_data[0], 8'h12);
    check_flags("stop");

    // overrun: five frames into a four-deep FIFO with no consumer
    ready_mode = 0;
    cycles(3);
    pop_log0.delete();
    for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 0, 1'b1);
    cmp("ovr_pulses", n_ov[0], 1);
    @(negedge clk);
    cmp("ovr_valid", bus0.rx_valid, 1);
    cmp("ovr_head", bus0.rx_data, 8'h01);
    drain("ovr");
    cmp("ovr_pop_count", pop_log0.size(), 4);
    for (int i = 0; i < 4 && i < pop_log0.size(); i++)
      cmp($sformatf("ovr_pop%0d", i), pop_log0[i], i + 1);
    check_flags("ovr");

    // reset in the middle of the data bits of 0xFF
    v0 = n_valid[0];
    rx0 = 1'b0;
    cycles(BIT_CLKS);
    rx0 = 1'b1;
    cycles(3 * BIT_CLKS + 20);
    @(negedge clk);
    cmp("midrst_busy_before", busy0, 1);
    rst = 1'b1;
    cycles(2);
    @(negedge clk);
    cmp("midrst_busy_in_reset", busy0, 0);
    rst = 1'b0;
    cycles(7 * BIT_CLKS);
    @(negedge clk);
    cmp("midrst_busy_after", busy0, 0);
    cmp("midrst_no_write", n_valid[0] - v0, 0);
    send_frame(0, 8'h81, 0, 1'b1);
    cmp("midrst_next_data", last_data[0], 8'h81);
    cmp("midrst_next_write", n_valid[0] - v0, 1);
    check_flags("midrst");

    // randomized traffic with random consumer stalls
    ready_mode = 2;
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom);
      err = ($urandom_range(0, 4) == 0);
      send_frame(0, d, 0, !err);
      cycles($urandom_range(1, 40));
    end
    for (int n = 0; n < 8; n++) begin
      d   = 8'($urandom);
      pm  = $urandom_range(1, 2);
      err = ($urandom_range(0, 4) == 0);
      send_frame(1, d, pm, !err);
      cycles($urandom_range(1, 40));
    end
    drain("rand");
    check_flags("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
